// File: rtl/vga_agc_ctrl_if.sv
// Sample-stream and gain-code bundle for the receive-chain AGC.
// master drives samples/thresholds, slave returns the VGA gain code.
interface vga_agc_ctrl_if #(
    parameter int ADC_W = 8
);
    logic             enable;
    logic [ADC_W-1:0] sample;
    logic             sample_valid;
    logic [ADC_W-1:0] thr_hi;
    logic [ADC_W-1:0] thr_lo;
    logic [3:0]       vga_code;
    logic             code_upd;
    logic             locked;

    modport master (
        output enable, sample, sample_valid, thr_hi, thr_lo,
        input  vga_code, code_upd, locked
    );

    modport slave (
        input  enable, sample, sample_valid, thr_hi, thr_lo,
        output vga_code, code_upd, locked
    );
endinterface

// File: rtl/vga_agc_ctrl.sv
// Closed-loop VGA gain controller: peak-per-window, +/-1 steps, settle, lock.
// Define AGC_COARSE_EN to add +/-4 coarse steps on clipping or deep underrange.
module vga_agc_ctrl #(
    parameter int ADC_W     = 8,
    parameter int WIN_LOG2  = 5,
    parameter int SETTLE    = 16,
    parameter int INIT_CODE = 8,
    parameter int LOCK_CNT  = 4
) (
    input logic         clock,
    input logic         reset_n,
    vga_agc_ctrl_if.slave bus
);
    localparam int ST_W = $clog2(SETTLE + 1);
    localparam int LK_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_DEC,
        ST_SET
    } state_t;

    state_t             state, state_n;
    logic [ADC_W-1:0]   peak, peak_n;
    logic [WIN_LOG2-1:0] win_cnt, win_cnt_n;
    logic [ST_W-1:0]    set_cnt, set_cnt_n;
    logic [LK_W-1:0]    lock_cnt, lock_cnt_n;
    logic [3:0]         code, code_n;
    logic               upd, upd_n;
    logic               lock_q, lock_n;
    logic               peak_hi, peak_lo;
    logic               coarse_dn, coarse_up;

    assign peak_hi = peak > bus.thr_hi;
    assign peak_lo = peak < bus.thr_lo;

`ifdef AGC_COARSE_EN
    assign coarse_dn = (&peak) && (code >= 4'd4);
    assign coarse_up = (peak < (bus.thr_lo >> 2)) && (code <= 4'd11);
`else
    assign coarse_dn = 1'b0;
    assign coarse_up = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        peak_n     = peak;
        win_cnt_n  = win_cnt;
        set_cnt_n  = set_cnt;
        lock_cnt_n = lock_cnt;
        code_n     = code;
        upd_n      = 1'b0;
        if (!bus.enable) begin
            // code is held across disable; everything else restarts
            state_n    = ST_IDLE;
            peak_n     = '0;
            win_cnt_n  = '0;
            set_cnt_n  = '0;
            lock_cnt_n = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_n   = ST_MEAS;
                    peak_n    = '0;
                    win_cnt_n = '0;
                end
                ST_MEAS: begin
                    if (bus.sample_valid) begin
                        if (bus.sample > peak)
                            peak_n = bus.sample;
                        win_cnt_n = win_cnt + 1'b1;
                        if (&win_cnt)
                            state_n = ST_DEC;
                    end
                end
                ST_DEC: begin
                    state_n   = ST_MEAS;
                    peak_n    = '0;
                    win_cnt_n = '0;
                    set_cnt_n = '0;
                    if (coarse_dn)
                        code_n = code - 4'd4;
                    else if (coarse_up)
                        code_n = code + 4'd4;
                    else if (peak_hi) begin
                        if (code != 4'd0)
                            code_n = code - 4'd1;
                        else
                            lock_cnt_n = '0;
                    end else if (peak_lo) begin
                        if (code != 4'd15)
                            code_n = code + 4'd1;
                        else
                            lock_cnt_n = '0;
                    end else if (lock_cnt != LK_W'(LOCK_CNT))
                        lock_cnt_n = lock_cnt + 1'b1;
                    if (code_n != code) begin
                        state_n    = ST_SET;
                        lock_cnt_n = '0;
                        upd_n      = 1'b1;
                    end
                end
                ST_SET: begin
                    if (set_cnt == ST_W'(SETTLE - 1)) begin
                        state_n   = ST_MEAS;
                        peak_n    = '0;
                        win_cnt_n = '0;
                    end else
                        set_cnt_n = set_cnt + 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end
        lock_n = (lock_cnt_n == LK_W'(LOCK_CNT));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            peak     <= '0;
            win_cnt  <= '0;
            set_cnt  <= '0;
            lock_cnt <= '0;
            code     <= 4'(INIT_CODE);
            upd      <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state    <= state_n;
            peak     <= peak_n;
            win_cnt  <= win_cnt_n;
            set_cnt  <= set_cnt_n;
            lock_cnt <= lock_cnt_n;
            code     <= code_n;
            upd      <= upd_n;
            lock_q   <= lock_n;
        end
    end

    assign bus.vga_code = code;
    assign bus.code_upd = upd;
    assign bus.locked   = lock_q;
endmodule

// File: tb/tb_vga_agc_ctrl.sv
// Scoreboard bench for vga_agc_ctrl: window-level gain model predicts
// every visible output change; a negedge monitor pops and compares.
module tb_vga_agc_ctrl;
    localparam int WIN  = 32;
    localparam int SETL = 16;
    localparam int LOCK = 4;

    typedef struct packed {
        logic [3:0] code;
        logic       upd;
        logic       locked;
    } ev_t;

    logic clock;
    logic reset_n;
    vga_agc_ctrl_if #(.ADC_W(8)) ifc ();

    vga_agc_ctrl dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    ev_t  q[$];
    bit   mon_on   = 0;
    logic [3:0] p_code;
    logic       p_locked;

    int m_code = 8;
    int m_lock = 0;
    int thi    = 200;
    int tlo    = 100;

    always @(negedge clock) begin
        if (mon_on) begin
            if (ifc.code_upd || ifc.locked !== p_locked ||
                ifc.vga_code !== p_code) begin
                ev_t got, exp;
                got = '{code: ifc.vga_code, upd: ifc.code_upd,
                        locked: ifc.locked};
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got code=%0d upd=%0b locked=%0b required no change",
                             got.code, got.upd, got.locked);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL event got code=%0d upd=%0b locked=%0b required code=%0d upd=%0b locked=%0b",
                                 got.code, got.upd, got.locked,
                                 exp.code, exp.upd, exp.locked);
                    end
                end
            end
            p_code   = ifc.vga_code;
            p_locked = ifc.locked;
        end
    end

    task automatic drive(input logic en, input logic v, input logic [7:0] s);
        ifc.enable       = en;
        ifc.sample_valid = v;
        ifc.sample       = s;
        ifc.thr_hi       = 8'(thi);
        ifc.thr_lo       = 8'(tlo);
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Applies the gain rules to one finished window; returns 1 on code change.
    function automatic bit model_decide(input int pk);
        int  nc      = m_code;
        bit  done    = 0;
        bit  was_lck = (m_lock == LOCK);
        bit  now_lck;
`ifdef AGC_COARSE_EN
        if (pk == 255 && m_code >= 4) begin
            nc = m_code - 4; done = 1;
        end else if (pk < tlo / 4 && m_code <= 11) begin
            nc = m_code + 4; done = 1;
        end
`endif
        if (!done) begin
            if (pk > thi) begin
                if (m_code > 0) nc = m_code - 1;
                else m_lock = 0;
            end else if (pk < tlo) begin
                if (m_code < 15) nc = m_code + 1;
                else m_lock = 0;
            end else if (m_lock < LOCK)
                m_lock++;
        end
        if (nc != m_code) begin
            m_code = nc;
            m_lock = 0;
            q.push_back('{code: 4'(m_code), upd: 1'b1, locked: 1'b0});
            return 1;
        end
        now_lck = (m_lock == LOCK);
        if (now_lck != was_lck)
            q.push_back('{code: 4'(m_code), upd: 1'b0, locked: now_lck});
        return 0;
    endfunction

    function automatic logic [7:0] junk();
        return ($urandom_range(0, 1) == 1) ? 8'hff : 8'($urandom);
    endfunction

    task automatic window(input int lo_v, input int hi_v, input int gap_pct);
        int pk = 0;
        int n  = 0;
        bit chg;
        while (n < WIN) begin
            if ($urandom_range(0, 99) < gap_pct)
                drive(1'b1, 1'b0, junk());
            else begin
                int s = $urandom_range(lo_v, hi_v);
                if (s > pk) pk = s;
                n++;
                drive(1'b1, 1'b1, 8'(s));
            end
        end
        chg = model_decide(pk);
        drive(1'b1, 1'($urandom_range(0, 1)), junk());
        if (chg)
            repeat (SETL) drive(1'b1, 1'($urandom_range(0, 1)), junk());
    endtask

    task automatic drop_mid();
        int k = $urandom_range(1, WIN - 1);
        for (int i = 0; i < k; i++)
            drive(1'b1, 1'b1, 8'hff);
        if (m_lock == LOCK)
            q.push_back('{code: 4'(m_code), upd: 1'b0, locked: 1'b0});
        m_lock = 0;
        repeat ($urandom_range(1, 3)) drive(1'b0, 1'b1, junk());
        drive(1'b1, 1'b0, junk());
    endtask

    initial begin
        reset_n = 1'b0;
        ifc.enable = 1'b0; ifc.sample_valid = 1'b0; ifc.sample = '0;
        ifc.thr_hi = 8'd200; ifc.thr_lo = 8'd100;
        repeat (3) @(posedge clock);
        #1;
        check("reset_code", int'(ifc.vga_code), 8);
        check("reset_upd", int'(ifc.code_upd), 0);
        check("reset_locked", int'(ifc.locked), 0);
        reset_n = 1'b1;
        @(negedge clock);
        p_code = ifc.vga_code; p_locked = ifc.locked;
        mon_on = 1;
        @(posedge clock); #1;

        repeat (100) drive(1'b0, 1'b1, 8'hff);
        check("idle_code_held", int'(ifc.vga_code), 8);
        drive(1'b1, 1'b0, 8'h00);

        window(250, 250, 0);
        for (int w = 0; w < LOCK; w++) window(150, 150, 20);
        window(20, 20, 10);
        for (int w = 0; w < 11; w++) window(255, 255, 15);
        check("floor_code", int'(ifc.vga_code), 0);
        for (int w = 0; w < 17; w++) window(0, 20, 15);
        check("ceiling_code", int'(ifc.vga_code), 15);
        for (int w = 0; w < LOCK + 1; w++) window(100, 200, 10);
        drop_mid();
        window(150, 150, 30);

        for (int w = 0; w < 80; w++) begin
            if ($urandom_range(0, 9) == 0) begin
                tlo = $urandom_range(0, 255);
                thi = $urandom_range(0, 255);
            end else begin
                tlo = $urandom_range(0, 200);
                thi = tlo + $urandom_range(0, 55);
            end
            if ($urandom_range(0, 4) == 0) drop_mid();
            begin
                int hv = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
                window($urandom_range(0, hv), hv, $urandom_range(0, 40));
            end
        end

        repeat (5) drive(1'b1, 1'b0, junk());
        check("queue_drained", q.size(), 0);
        check("final_code", int'(ifc.vga_code), m_code);

        mon_on = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 8'h05);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_reset_code", int'(ifc.vga_code), 8);
        check("midrun_reset_upd", int'(ifc.code_upd), 0);
        check("midrun_reset_locked", int'(ifc.locked), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
